// File: rtl/frame_buf_mem_arb.sv
// Round-robin arbiter sharing one memory command port between frame buffer write and read sides.
// Optional grant statistics counters are built when ARB_STATS_EN is defined.
module frame_buf_mem_arb #(
    parameter int ADDR_WIDTH = 29,
    parameter int MAX_BURST  = 16,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_in,
    input  logic                  rd_en_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  avl_ready,
    output logic                  mem_write_req,
    output logic                  mem_read_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  wr_rdy,
    output logic                  rd_rdy,
`ifdef ARB_STATS_EN
    output logic [STAT_WIDTH-1:0] wr_grant_cnt,
    output logic [STAT_WIDTH-1:0] rd_grant_cnt,
`endif
    output logic [1:0]            dbg_state_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    if (MAX_BURST < 1 || STAT_WIDTH < 1) begin : g_bad_cfg
        $error("frame_buf_mem_arb: MAX_BURST and STAT_WIDTH must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_e;

    state_e        state_q;
    logic          last_rd_q;
    logic [BW-1:0] burst_q;
    logic [BW-1:0] burst_inc;
    logic          wr_req;
    logic          rd_req;

    assign wr_req = !wr_en_in;
    assign rd_req = !rd_en_in;

    // Valid/ready: a command is accepted in any cycle where *_req and avl_ready are both high;
    // *_rdy marks that cycle and the requester advances its address on the same edge.
    assign mem_write_req = (state_q == S_WR) && wr_req && !reset;
    assign mem_read_req  = (state_q == S_RD) && rd_req && !reset;
    assign wr_rdy        = mem_write_req && avl_ready;
    assign rd_rdy        = mem_read_req && avl_ready;
    assign dbg_state_o   = state_q;

    always_comb begin
        mem_addr = '0;
        if (!reset) begin
            case (state_q)
                S_WR:    mem_addr = wr_addr;
                S_RD:    mem_addr = rd_addr;
                default: mem_addr = '0;
            endcase
        end
    end

    // Saturating so a lone streaming requester never wraps the burst count.
    assign burst_inc = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_rd_q <= 1'b1;
            burst_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    burst_q <= '0;
                    if (wr_req && (!rd_req || last_rd_q)) begin
                        state_q <= S_WR;
                    end else if (rd_req) begin
                        state_q <= S_RD;
                    end
                end
                S_WR: begin
                    if (wr_rdy) begin
                        last_rd_q <= 1'b0;
                        if (burst_inc == BURST_MAX && rd_req) begin
                            state_q <= S_RD;
                            burst_q <= '0;
                        end else begin
                            burst_q <= burst_inc;
                        end
                    end else if (!wr_req) begin
                        burst_q <= '0;
                        state_q <= rd_req ? S_RD : S_IDLE;
                    end
                end
                S_RD: begin
                    if (rd_rdy) begin
                        last_rd_q <= 1'b1;
                        if (burst_inc == BURST_MAX && wr_req) begin
                            state_q <= S_WR;
                            burst_q <= '0;
                        end else begin
                            burst_q <= burst_inc;
                        end
                    end else if (!rd_req) begin
                        burst_q <= '0;
                        state_q <= wr_req ? S_WR : S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    burst_q <= '0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [STAT_WIDTH-1:0] wr_cnt_q;
    logic [STAT_WIDTH-1:0] rd_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_rdy && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (rd_rdy && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
        end
    end

    assign wr_grant_cnt = wr_cnt_q;
    assign rd_grant_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_frame_buf_mem_arb.sv
// Directed bench for frame_buf_mem_arb (MAX_BURST=4, STAT_WIDTH=4) with an expected-vector queue
// checked by an independent negedge monitor.
module tb_frame_buf_mem_arb;
  localparam int AW = 29;
  localparam int EW = AW + 6;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          wr_en_in;
  logic          rd_en_in;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          avl_ready;
  logic          mem_write_req;
  logic          mem_read_req;
  logic [AW-1:0] mem_addr;
  logic          wr_rdy;
  logic          rd_rdy;
  logic [1:0]    dbg_state;
`ifdef ARB_STATS_EN
  logic [3:0]    wr_grant_cnt;
  logic [3:0]    rd_grant_cnt;
`endif

  frame_buf_mem_arb #(
    .ADDR_WIDTH (AW),
    .MAX_BURST  (4),
    .STAT_WIDTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en_in      (wr_en_in),
    .rd_en_in      (rd_en_in),
    .wr_addr       (wr_addr),
    .rd_addr       (rd_addr),
    .avl_ready     (avl_ready),
    .mem_write_req (mem_write_req),
    .mem_read_req  (mem_read_req),
    .mem_addr      (mem_addr),
    .wr_rdy        (wr_rdy),
    .rd_rdy        (rd_rdy),
`ifdef ARB_STATS_EN
    .wr_grant_cnt  (wr_grant_cnt),
    .rd_grant_cnt  (rd_grant_cnt),
`endif
    .dbg_state_o   (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  // expected vector layout: {state, wreq, rreq, wrdy, rrdy, addr}
  task automatic drive(input logic rst, input logic wen, input logic ren,
                       input int wa, input int ra, input logic ar,
                       input logic [1:0] es, input logic ew, input logic er, input int ea);
    @(posedge clk);
    #1;
    reset     = rst;
    wr_en_in  = wen;
    rd_en_in  = ren;
    wr_addr   = AW'(wa);
    rd_addr   = AW'(ra);
    avl_ready = ar;
    exp_q.push_back({es, ew, er, ew & ar, er & ar, AW'(ea)});
  endtask

`ifdef ARB_STATS_EN
  task automatic chk_stat(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
`endif

  // monitor
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_act;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {dbg_state, mem_write_req, mem_read_req, wr_rdy, rd_rdy, mem_addr};
        n_vec++;
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL vec%0d: got st=%0d wreq=%b rreq=%b wrdy=%b rrdy=%b addr=%0d, want st=%0d wreq=%b rreq=%b wrdy=%b rrdy=%b addr=%0d",
                   n_vec, mon_act[EW-1 -: 2], mon_act[AW+3], mon_act[AW+2], mon_act[AW+1], mon_act[AW],
                   mon_act[AW-1:0], mon_exp[EW-1 -: 2], mon_exp[AW+3], mon_exp[AW+2], mon_exp[AW+1],
                   mon_exp[AW], mon_exp[AW-1:0]);
        end
      end
    end
  end

  // stimulus
  int wa_v;
  int ra_v;
  initial begin
    reset     = 1'b1;
    wr_en_in  = 1'b0;
    rd_en_in  = 1'b1;
    wr_addr   = AW'(5);
    rd_addr   = '0;
    avl_ready = 1'b1;

    // reset with write request held, then grant latency and deassert to IDLE
    drive(1, 0, 1, 5, 0, 1, ST_IDLE, 0, 0, 0);
    drive(1, 0, 1, 5, 0, 1, ST_IDLE, 0, 0, 0);
    drive(0, 0, 1, 5, 0, 0, ST_IDLE, 0, 0, 0);
    drive(0, 0, 1, 5, 0, 0, ST_WR,   1, 0, 5);
    drive(0, 1, 1, 5, 0, 0, ST_WR,   0, 0, 5);
    drive(0, 1, 1, 5, 0, 0, ST_IDLE, 0, 0, 0);

    // lone writer streams 20 accepts from address 2 without bubbles
    drive(0, 0, 1, 2, 50, 1, ST_IDLE, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive(0, 0, 1, 2 + k, 50, 1, ST_WR, 1, 0, 2 + k);
    // read arrives with burst count saturated: one more write, then switch
    drive(0, 0, 0, 22, 50, 1, ST_WR, 1, 0, 22);
`ifdef ARB_STATS_EN
    chk_stat("wr_grant_cnt_sat", wr_grant_cnt, 4'd15);
    chk_stat("rd_grant_cnt_zero", rd_grant_cnt, 4'd0);
`endif
    drive(0, 1, 0, 23, 50, 1, ST_RD,   0, 1, 50);
    drive(0, 1, 1, 23, 51, 1, ST_RD,   0, 0, 51);
    drive(0, 1, 1, 23, 51, 1, ST_IDLE, 0, 0, 0);

    // reset, then both requesting: write wins the tie, groups of 4 alternate
    drive(1, 0, 0, 200, 300, 1, ST_IDLE, 0, 0, 0);
    drive(0, 0, 0, 200, 300, 1, ST_IDLE, 0, 0, 0);
    wa_v = 200;
    ra_v = 300;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) begin
        if (g == 1) begin
          drive(0, 0, 0, wa_v, ra_v, 1, ST_RD, 0, 1, ra_v);
          ra_v++;
        end else begin
          drive(0, 0, 0, wa_v, ra_v, 1, ST_WR, 1, 0, wa_v);
          wa_v++;
        end
      end
    end
    // read drops with write pending -> WR; then memory stall for 3 cycles
    drive(0, 0, 1, wa_v, ra_v, 1, ST_RD, 0, 0, ra_v);
    for (int s = 0; s < 3; s++) drive(0, 0, 1, wa_v, ra_v, 0, ST_WR, 1, 0, wa_v);
    drive(0, 0, 1, wa_v, ra_v, 1, ST_WR, 1, 0, wa_v);
    wa_v++;
    // write drops with read pending -> RD next cycle
    drive(0, 1, 0, wa_v, ra_v, 1, ST_WR, 0, 0, wa_v);
    drive(0, 1, 0, wa_v, ra_v, 1, ST_RD, 0, 1, ra_v);
    ra_v++;
    drive(0, 1, 1, wa_v, ra_v, 1, ST_RD,   0, 0, ra_v);
    drive(0, 1, 1, wa_v, ra_v, 1, ST_IDLE, 0, 0, 0);

    // reset in the middle of a write stream drops the command
    drive(0, 0, 1, wa_v, ra_v, 1, ST_IDLE, 0, 0, 0);
    drive(0, 0, 1, wa_v, ra_v, 1, ST_WR,   1, 0, wa_v);
    wa_v++;
    drive(1, 0, 1, wa_v, ra_v, 1, ST_WR,   0, 0, 0);
    drive(0, 0, 1, wa_v, ra_v, 1, ST_IDLE, 0, 0, 0);
    drive(0, 0, 1, wa_v, ra_v, 1, ST_WR,   1, 0, wa_v);
    wa_v++;
    drive(0, 1, 1, wa_v, ra_v, 1, ST_WR,   0, 0, wa_v);
`ifdef ARB_STATS_EN
    chk_stat("wr_grant_cnt_after_reset", wr_grant_cnt, 4'd1);
    chk_stat("rd_grant_cnt_after_reset", rd_grant_cnt, 4'd0);
`endif
    drive(0, 1, 1, wa_v, ra_v, 1, ST_IDLE, 0, 0, 0);

    // final report
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
